// File: rtl/arr_frame_pkg.sv
// Shared defaults, frame type and receiver state encoding for arr_frame_rx.
package arr_frame_pkg;

  localparam int BEAT_W_DEF = 4;
  localparam int ROWS_DEF   = 2;
  localparam int COLS_DEF   = 3;

  typedef logic [0:ROWS_DEF-1][0:COLS_DEF-1][BEAT_W_DEF:1] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } rx_state_e;

endpackage

// File: rtl/arr_beat_xzdet.sv
// Per-beat x/z detector. Flags a beat holding any x or z bit.
// With ARR_FRAME_RX_XZ_SCRUB_EN defined, x/z bits are forced to 0 on dout;
// otherwise dout is the beat bit-exact.
module arr_beat_xzdet #(
  parameter int BEAT_W = 4
) (
  input  logic [BEAT_W:1] din,
  output logic [BEAT_W:1] dout,
  output logic            xz
);

  // Per-bit 4-state check: a bit that is neither exactly 0 nor exactly 1 is x/z.
  always_comb begin
    xz   = 1'b0;
    dout = din;
    for (int unsigned i = 1; i <= BEAT_W; i++) begin
      if (!((din[i] === 1'b0) || (din[i] === 1'b1))) begin
        xz = 1'b1;
`ifdef ARR_FRAME_RX_XZ_SCRUB_EN
        dout[i] = 1'b0;
`endif
      end
    end
  end

endmodule

// File: rtl/arr_frame_rx.sv
// Frame receiver: collects ROWS*COLS beats row-major into a frame, holds it
// until consumed, flags x/z-carrying beats and pulses out_err on framing errors.
// Optional feature macro: ARR_FRAME_RX_XZ_SCRUB_EN (store x/z bits as 0).
module arr_frame_rx
  import arr_frame_pkg::*;
#(
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int COLS   = COLS_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_sof,
  input  logic [BEAT_W:1]                      in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [0:ROWS-1][0:COLS-1][BEAT_W:1]  out_frame,
  output logic [0:ROWS*COLS-1]                 out_xz_mask,
  output logic                                 out_err
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(N + 1);

  rx_state_e                             state_q, state_d;
  logic [CW-1:0]                         cnt_q;
  logic [0:ROWS-1][0:COLS-1][BEAT_W:1]   frame_q;
  logic [0:N-1]                          mask_q, mask_set;
  logic                                  err_q, err_d;
  logic                                  accept, start, store, consume;
  logic [CW-1:0]                         idx;
  logic [BEAT_W:1]                       beat_st;
  logic                                  beat_xz;

  arr_beat_xzdet #(.BEAT_W(BEAT_W)) u_xzdet (
    .din  (in_data),
    .dout (beat_st),
    .xz   (beat_xz)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic, handshake and framing-error detection.
  always_comb begin
    state_d  = state_q;
    in_ready = (state_q != HOLD) && !rst;
    accept   = in_valid && in_ready;
    start    = 1'b0;
    store    = 1'b0;
    consume  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_sof) begin
            start   = 1'b1;
            store   = 1'b1;
            state_d = (N == 1) ? HOLD : COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          store = 1'b1;
          if (in_sof) begin
            err_d   = 1'b1;
            start   = 1'b1;
            state_d = (N == 1) ? HOLD : COLLECT;
          end else if (cnt_q == CW'(N - 1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          consume = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    idx      = start ? '0 : cnt_q;
    mask_set = '0;
    mask_set[idx] = beat_xz;
  end

  // Beat storage, x/z mask and beat counter; a restart begins a fresh mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      frame_q <= '0;
      mask_q  <= '0;
    end else if (store) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          if (idx == CW'(r * COLS + c)) frame_q[r][c] <= beat_st;
        end
      end
      mask_q <= (start ? '0 : mask_q) | mask_set;
      cnt_q  <= (idx == CW'(N - 1)) ? '0 : idx + 1'b1;
    end else if (consume) begin
      mask_q <= '0;
    end
  end

  // One-cycle framing-error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign out_valid   = (state_q == HOLD);
  assign out_frame   = frame_q;
  assign out_xz_mask = mask_q;
  assign out_err     = err_q;

endmodule

// File: doc/arr_frame_rx.md
ARR_FRAME_RX -- requirements
Module: arr_frame_rx

Interface
REQ-001 The block SHALL have parameter BEAT_W, default 4, meaning bits per beat, equal to the innermost element [BEAT_W:1].
REQ-002 The block SHALL have parameter ROWS, default 2, meaning the outer dimension of the frame.
REQ-003 The block SHALL have parameter COLS, default 3, meaning the middle dimension of the frame; beats per frame N = ROWS*COLS.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a beat is offered.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 The block SHALL have port in_sof, input, 1 bit: the offered beat is the first of a frame.
REQ-009 The block SHALL have port in_data, input, 4-state logic [BEAT_W:1]: beat payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a complete frame is held.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the frame.
REQ-012 The block SHALL have port out_frame, output, logic [0:ROWS-1][0:COLS-1][BEAT_W:1]: the assembled frame.
REQ-013 The block SHALL have port out_xz_mask, output, [0:N-1]: bit k set means beat k contained an x or z bit.
REQ-014 The block SHALL have port out_err, output, 1 bit: one-cycle framing-error pulse.

Function
REQ-015 A beat SHALL be accepted exactly when in_valid && in_ready is high at a rising clk.
REQ-016 The FSM SHALL have three states: IDLE, COLLECT and HOLD; in_ready SHALL be 1 in IDLE and COLLECT and 0 in HOLD.
REQ-017 In IDLE, an accepted beat with in_sof=1 SHALL be stored as beat 0, set the beat counter to 1 and move to COLLECT (move straight to HOLD when N=1).
REQ-018 In IDLE, an accepted beat with in_sof=0 SHALL be dropped and SHALL pulse out_err for one cycle.
REQ-019 Beat k SHALL be stored row-major into out_frame[k/COLS][k%COLS], so beat 0 maps to [0][0] and beat N-1 to [ROWS-1][COLS-1].
REQ-020 In COLLECT, an accepted beat with in_sof=1 SHALL pulse out_err, discard the partial frame, clear out_xz_mask and be stored as the new beat 0.
REQ-021 In COLLECT, acceptance of beat N-1 SHALL move the FSM to HOLD, and out_valid SHALL be 1 in the following cycle (latency 1 cycle from the last beat).
REQ-022 In HOLD, out_frame and out_xz_mask SHALL remain stable until out_valid && out_ready; that cycle SHALL return the FSM to IDLE and clear out_xz_mask.
REQ-023 Because in_ready=0 in HOLD, no beat SHALL be accepted in the cycle in which a frame is consumed; the next beat is accepted no earlier than the following cycle.
REQ-024 out_xz_mask[k] SHALL be computed per beat using a 4-state case-equality check on each bit of in_data.
REQ-025 The beat counter SHALL be ceil(log2(N+1)) bits wide and SHALL never wrap past N-1.
REQ-026 out_frame SHALL be ignored by the consumer while out_valid=0, and its content in that state is unspecified.

Reset
REQ-027 Asserting rst SHALL immediately force the FSM to IDLE, the counter to 0, out_valid=0, out_err=0, out_xz_mask=0 and out_frame=0, including in the middle of a frame or in HOLD.
REQ-028 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst is released.

Configuration
REQ-029 With ARR_FRAME_RX_XZ_SCRUB_EN defined, every x or z bit SHALL be stored as 0 in out_frame, while out_xz_mask still reports the original x/z status.
REQ-030 Without ARR_FRAME_RX_XZ_SCRUB_EN, beats SHALL be stored bit-exact, including x and z.

Structure
REQ-031 Package arr_frame_pkg SHALL hold the default BEAT_W, ROWS and COLS values, the frame_t packed typedef and the rx_state_e enum (IDLE, COLLECT, HOLD).
REQ-032 Per-beat x/z detection and scrub SHALL live in a single combinational sub-module, arr_beat_xzdet.

Verification
REQ-033 Scenario: 6 beats 'h1..'h6 with in_sof on the first beat and out_ready=1 -> out_valid 1 cycle after beat 6, out_frame[0][0]='h1, out_frame[1][2]='h6, out_xz_mask=0.
REQ-034 Scenario: beat 2 = 'b1xz0 -> out_xz_mask=6'b010000; out_frame[0][1] is 'b1xz0 without the macro and 'b1000 with it.
REQ-035 Scenario: in_sof asserted on beat 4 of a frame -> one out_err pulse, frame restarts, the next 5 beats complete it, and out_frame[0][0] equals the beat that restarted it.
REQ-036 Scenario: full frame with out_ready=0 for 10 cycles -> in_ready=0 and out_frame stable throughout; out_ready=1 -> IDLE next cycle.
REQ-037 Scenario: rst pulsed after beat 3 -> all outputs 0; a fresh 6-beat frame then completes correctly.
REQ-038 Scenario: a beat with in_sof=0 in IDLE -> dropped, out_err pulses once, no state change.
